fifo_sync: RTL and testbench

Single-clock, parametrised FIFO: the next generation of the team's `fifo` block. Generalised in data width and depth, with a selectable read mode (registered or first-word-fall-through), programmable almost-full/almost-empty thresholds, an exact fill level, and per-cycle error pulses for rejected requests. It buffers between producer and consumer logic sharing one clock domain.

---
 rtl/fifo_defs_pkg.sv | 13 +
 rtl/fifo_ram.sv | 26 ++
 rtl/fifo_sync.sv | 121 ++++++++++++
 tb/tb_fifo_sync.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fifo_defs_pkg.sv
// Shared constants for the fifo_sync family: read-mode selectors and the
// pointer-width helper.
package fifo_defs;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointers carry one extra wrap bit above the storage index.
    function automatic int ptr_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for fifo_sync: one synchronous write port, one asynchronous
// read port, no reset.
module fifo_ram #(
    parameter int W = 8,
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [N-1:0] waddr_i,
    input  logic [W-1:0] wdata_i,
    input  logic [N-1:0] raddr_i,
    output logic [W-1:0] rdata_o
);

    logic [W-1:0] mem_q [0:(1<<N)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock parametrised FIFO with registered or first-word-fall-through
// read, almost-full/almost-empty flags, fill level and rejection pulses.
module fifo_sync
    import fifo_defs::*;
#(
    parameter int W    = 8,
    parameter int N    = 3,
    parameter int FWFT = FIFO_STD,
    parameter int AF   = (1 << N) - 1,
    parameter int AE   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in,
    input  logic         put,
    output logic         full,
    output logic         afull,
    output logic [W-1:0] out,
    input  logic         get,
    output logic         empty,
    output logic         aempty,
    output logic [N:0]   level,
    output logic         err_put,
    output logic         err_get
);

    localparam int PW = ptr_w(N);

    logic [PW-1:0] w_q, w_d, r_q, r_d, level_q, level_d;
    logic          empty_q, empty_d, full_q, full_d;
    logic          afull_q, afull_d, aempty_q, aempty_d;
    logic          err_put_q, err_put_d, err_get_q, err_get_d;
    logic          put_ok_s, get_ok_s;
    logic [W-1:0]  rd_data_s;

    fifo_ram #(.W(W), .N(N)) u_ram (
        .clk     (clk),
        .we_i    (put_ok_s),
        .waddr_i (w_q[N-1:0]),
        .wdata_i (in),
        .raddr_i (r_q[N-1:0]),
        .rdata_o (rd_data_s)
    );

    // Acceptance uses only the registered flags, so a simultaneous get never
    // frees room for a put while full, nor does a put feed a get while empty.
    always_comb begin
        put_ok_s  = put && !full_q;
        get_ok_s  = get && !empty_q;
        w_d       = w_q + {{(PW-1){1'b0}}, put_ok_s};
        r_d       = r_q + {{(PW-1){1'b0}}, get_ok_s};
        level_d   = w_d - r_d;
        empty_d   = (w_d == r_d);
        full_d    = (w_d[N-1:0] == r_d[N-1:0]) && (w_d[N] != r_d[N]);
        afull_d   = (level_d >= PW'(AF));
        aempty_d  = (level_d <= PW'(AE));
        err_put_d = put && full_q;
        err_get_d = get && empty_q;
    end

    // Pointer, flag and error-pulse state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q       <= {PW{1'b0}};
            r_q       <= {PW{1'b0}};
            level_q   <= {PW{1'b0}};
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            err_put_q <= 1'b0;
            err_get_q <= 1'b0;
        end else begin
            w_q       <= w_d;
            r_q       <= r_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            err_put_q <= err_put_d;
            err_get_q <= err_get_d;
        end
    end

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign out = rd_data_s;
        end else begin : g_std
            logic [W-1:0] out_q, out_d;

            always_comb begin
                if (get_ok_s) begin
                    out_d = rd_data_s;
                end else begin
                    out_d = out_q;
                end
            end

            // Registered read data
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_q <= {W{1'b0}};
                end else begin
                    out_q <= out_d;
                end
            end

            assign out = out_q;
        end
    endgenerate

    assign full    = full_q;
    assign afull   = afull_q;
    assign empty   = empty_q;
    assign aempty  = aempty_q;
    assign level   = level_q;
    assign err_put = err_put_q;
    assign err_get = err_get_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed, table-driven bench for fifo_sync (W=8, N=3, AF=6, AE=1) covering
// the registered-read and first-word-fall-through builds side by side.
module tb_fifo_sync;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       put = 1'b0;
    logic       get = 1'b0;

    logic       full, afull, empty, aempty, err_put, err_get;
    logic [7:0] dout;
    logic [3:0] level;
    logic       full_f, afull_f, empty_f, aempty_f, err_put_f, err_get_f;
    logic [7:0] dout_f;
    logic [3:0] level_f;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_sync #(.W(8), .N(3), .FWFT(0), .AF(6), .AE(1)) dut (
        .clk(clk), .reset(reset), .in(din), .put(put), .full(full),
        .afull(afull), .out(dout), .get(get), .empty(empty),
        .aempty(aempty), .level(level), .err_put(err_put), .err_get(err_get)
    );

    fifo_sync #(.W(8), .N(3), .FWFT(1), .AF(6), .AE(1)) dut_f (
        .clk(clk), .reset(reset), .in(din), .put(put), .full(full_f),
        .afull(afull_f), .out(dout_f), .get(get), .empty(empty_f),
        .aempty(aempty_f), .level(level_f), .err_put(err_put_f), .err_get(err_get_f)
    );

    typedef struct {
        logic       put;
        logic       get;
        logic [7:0] din;
        int         lvl;
        logic       ep;
        logic       eg;
        logic [7:0] out0;
        logic       fchk;
        logic [7:0] fout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic p, input logic g, input logic [7:0] d, input int lvl,
                       input logic ep, input logic eg, input logic [7:0] o0,
                       input logic fc, input logic [7:0] fo);
        vec_t v;
        v.put = p; v.get = g; v.din = d; v.lvl = lvl; v.ep = ep; v.eg = eg;
        v.out0 = o0; v.fchk = fc; v.fout = fo;
        vecs.push_back(v);
    endtask

    task automatic check_flags(input string tag, input int lvl);
        check({tag, " level"},  32'(level),  32'(lvl));
        check({tag, " empty"},  32'(empty),  32'(lvl == 0));
        check({tag, " full"},   32'(full),   32'(lvl == 8));
        check({tag, " afull"},  32'(afull),  32'(lvl >= 6));
        check({tag, " aempty"}, 32'(aempty), 32'(lvl <= 1));
        check({tag, " level_f"}, 32'(level_f), 32'(lvl));
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] exp_out0;

    initial begin
        // Fill 0x10..0x17, reject a 9th put, then drain with a boundary put+get.
        for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 8'(8'h10 + i), i + 1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10);
        add(1'b1, 1'b0, 8'hFF, 8, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10);
        add(1'b0, 1'b0, 8'h00, 8, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10);
        add(1'b1, 1'b1, 8'hEE, 7, 1'b1, 1'b0, 8'h10, 1'b1, 8'h11);
        for (int i = 1; i < 8; i++) add(1'b0, 1'b1, 8'h00, 7 - i, 1'b0, 1'b0, 8'(8'h10 + i), 1'(i < 7), 8'(8'h11 + i));
        add(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 8'h17, 1'b0, 8'h00);
        add(1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b1, 8'h17, 1'b1, 8'h33);
        add(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h33, 1'b0, 8'h00);
        add(1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 8'h33, 1'b1, 8'hA5);
        add(1'b1, 1'b0, 8'hA6, 2, 1'b0, 1'b0, 8'h33, 1'b1, 8'hA5);
        add(1'b1, 1'b0, 8'hA7, 3, 1'b0, 1'b0, 8'h33, 1'b1, 8'hA5);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset", 0);
        check("reset out", 32'(dout), 32'h0);
        check("reset err_put", 32'(err_put), 32'h0);
        check("reset err_get", 32'(err_get), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            put = vecs[k].put; get = vecs[k].get; din = vecs[k].din;
            @(posedge clk);
            #1;
            check_flags($sformatf("vec%0d", k), vecs[k].lvl);
            check($sformatf("vec%0d err_put", k), 32'(err_put), 32'(vecs[k].ep));
            check($sformatf("vec%0d err_get", k), 32'(err_get), 32'(vecs[k].eg));
            check($sformatf("vec%0d err_put_f", k), 32'(err_put_f), 32'(vecs[k].ep));
            check($sformatf("vec%0d err_get_f", k), 32'(err_get_f), 32'(vecs[k].eg));
            check($sformatf("vec%0d out", k), 32'(dout), 32'(vecs[k].out0));
            if (vecs[k].fchk) check($sformatf("vec%0d out_f", k), 32'(dout_f), 32'(vecs[k].fout));
        end

        // Simultaneous put+get at level 3 across several pointer wraps.
        exp_q = '{8'hA5, 8'hA6, 8'hA7};
        exp_out0 = 8'h33;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            put = 1'b1; get = 1'b1; din = 8'(8'hB0 + i);
            @(posedge clk);
            #1;
            exp_out0 = exp_q.pop_front();
            exp_q.push_back(8'(8'hB0 + i));
            check($sformatf("pg%0d level", i), 32'(level), 32'd3);
            check($sformatf("pg%0d err", i), 32'({err_put, err_get}), 32'd0);
            check($sformatf("pg%0d out", i), 32'(dout), 32'(exp_out0));
            check($sformatf("pg%0d out_f", i), 32'(dout_f), 32'(exp_q[0]));
        end

        // Raise level to 5, then reset asynchronously in mid-cycle.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            put = 1'b1; get = 1'b0; din = 8'(8'hC0 + i);
            @(posedge clk);
            #1;
            check($sformatf("pre-reset level%0d", i), 32'(level), 32'(4 + i));
        end
        @(negedge clk);
        put = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_flags("async reset", 0);
        check("async reset out", 32'(dout), 32'h0);
        check("async reset errs", 32'({err_put, err_get, err_put_f, err_get_f}), 32'h0);
        @(negedge clk);
        reset = 1'b0; put = 1'b1; din = 8'h5A;
        @(posedge clk);
        #1;
        check_flags("post-reset put", 1);
        check("post-reset out_f", 32'(dout_f), 32'h5A);
        check("post-reset err_put", 32'(err_put), 32'h0);
        @(negedge clk);
        put = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
